// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the RAM.
interface mem_arbiter_if;
  localparam int unsigned DW = 64;

  // Instruction-fetch port
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  // Load/store port
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_wmask;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  // RAM port
  logic          ram_en;
  logic [DW-1:0] ram_ridx;
  logic [DW-1:0] ram_rdata;
  logic          ram_wen;
  logic [DW-1:0] ram_widx;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_wmask;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output ram_en, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  ram_en, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch vs load/store) arbiter onto a single-ported word RAM.
// Load/store wins ties; fetch is forced through after STARVE_MAX straight losses.
module mem_arbiter #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_IF  = 2'd1,
    RESP_MEM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          store_q, store_d;
  logic          grant_if;

  // Byte address to RAM word index; offset wraps modulo 2^64, byte lane bits dropped.
  function automatic logic [DW-1:0] word_idx(input logic [DW-1:0] addr);
    logic [DW-1:0] off;
    off = addr - BASE;
    return off >> 3;
  endfunction

  // State, starvation counter and store flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      store_q  <= store_d;
    end
  end

  // Arbitration, RAM command in the grant cycle, and response decode.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    store_d       = store_q;
    grant_if      = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_ridx  = '0;
    bus.ram_wen   = 1'b0;
    bus.ram_widx  = '0;
    bus.ram_wdata = '0;
    bus.ram_wmask = '0;
    bus.if_ack    = 1'b0;
    bus.if_rdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Gating on rst keeps every output quiet while reset is held.
    if (rst) begin
      case (state_q)
        IDLE: begin
          grant_if = bus.if_req && (!bus.mem_req || (starve_q == CW'(STARVE_MAX)));
          if (grant_if) begin
            bus.ram_en   = 1'b1;
            bus.ram_ridx = word_idx(bus.if_addr);
            starve_d     = '0;
            state_d      = RESP_IF;
          end else if (bus.mem_req) begin
            store_d = bus.mem_we;
            state_d = RESP_MEM;
            if (bus.mem_we) begin
              bus.ram_wen   = 1'b1;
              bus.ram_widx  = word_idx(bus.mem_addr);
              bus.ram_wdata = bus.mem_wdata;
              bus.ram_wmask = bus.mem_wmask;
            end else begin
              bus.ram_en   = 1'b1;
              bus.ram_ridx = word_idx(bus.mem_addr);
            end
            if (bus.if_req && (starve_q < CW'(STARVE_MAX))) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
        RESP_IF: begin
          bus.if_ack   = 1'b1;
          bus.if_rdata = bus.ram_rdata;
          state_d      = IDLE;
        end
        RESP_MEM: begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = store_q ? '0 : bus.ram_rdata;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus corner sequences.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus_a();
  mem_arbiter_if bus_b();

  mem_arbiter #(.BASE(64'h8000_0000), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  mem_arbiter #(.BASE(64'h8000_0000), .STARVE_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  typedef struct {
    string       name;
    logic        if_req;
    logic [63:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_wmask;
    logic [63:0] ram_rdata;
    logic        g_en;
    logic [63:0] g_ridx;
    logic        g_wen;
    logic [63:0] g_widx;
    logic [63:0] g_wdata;
    logic [63:0] g_wmask;
    logic        r_if_ack;
    logic [63:0] r_if_rdata;
    logic        r_mem_ack;
    logic [63:0] r_mem_rdata;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input string nm,
    input logic ir, input logic [63:0] ia,
    input logic mr, input logic mw, input logic [63:0] ma, input logic [63:0] wd,
    input logic [63:0] wm, input logic [63:0] rd,
    input logic gen, input logic [63:0] gri, input logic gwen, input logic [63:0] gwi,
    input logic [63:0] gwd, input logic [63:0] gwm,
    input logic ria, input logic [63:0] rir, input logic rma, input logic [63:0] rmr);
    vec_t v;
    v.name = nm; v.if_req = ir; v.if_addr = ia;
    v.mem_req = mr; v.mem_we = mw; v.mem_addr = ma; v.mem_wdata = wd; v.mem_wmask = wm;
    v.ram_rdata = rd;
    v.g_en = gen; v.g_ridx = gri; v.g_wen = gwen; v.g_widx = gwi; v.g_wdata = gwd; v.g_wmask = gwm;
    v.r_if_ack = ria; v.r_if_rdata = rir; v.r_mem_ack = rma; v.r_mem_rdata = rmr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_a();
    bus_a.if_req = 1'b0; bus_a.if_addr = '0;
    bus_a.mem_req = 1'b0; bus_a.mem_we = 1'b0; bus_a.mem_addr = '0;
    bus_a.mem_wdata = '0; bus_a.mem_wmask = '0;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.if_req = v.if_req; bus_a.if_addr = v.if_addr;
    bus_a.mem_req = v.mem_req; bus_a.mem_we = v.mem_we; bus_a.mem_addr = v.mem_addr;
    bus_a.mem_wdata = v.mem_wdata; bus_a.mem_wmask = v.mem_wmask;
    bus_a.ram_rdata = v.ram_rdata;
  endtask

  // RAM command check; index/data fields only where the command defines them (all zero when idle).
  task automatic check_grant_a(input string t, input logic en, input logic [63:0] ridx,
                               input logic wen, input logic [63:0] widx,
                               input logic [63:0] wdata, input logic [63:0] wmask);
    chk({t, ".ram_en"}, 64'(bus_a.ram_en), 64'(en));
    chk({t, ".ram_wen"}, 64'(bus_a.ram_wen), 64'(wen));
    if (en || !wen) chk({t, ".ram_ridx"}, bus_a.ram_ridx, ridx);
    if (wen || !en) begin
      chk({t, ".ram_widx"}, bus_a.ram_widx, widx);
      chk({t, ".ram_wdata"}, bus_a.ram_wdata, wdata);
      chk({t, ".ram_wmask"}, bus_a.ram_wmask, wmask);
    end
  endtask

  task automatic check_resp_a(input string t, input logic ia, input logic [63:0] ir,
                              input logic ma, input logic [63:0] mr);
    chk({t, ".if_ack"}, 64'(bus_a.if_ack), 64'(ia));
    chk({t, ".if_rdata"}, bus_a.if_rdata, ir);
    chk({t, ".mem_ack"}, 64'(bus_a.mem_ack), 64'(ma));
    chk({t, ".mem_rdata"}, bus_a.mem_rdata, mr);
    chk({t, ".resp_ram_en"}, 64'(bus_a.ram_en), 64'd0);
    chk({t, ".resp_ram_wen"}, 64'(bus_a.ram_wen), 64'd0);
  endtask

  initial begin
    logic [63:0] b_idx [4];
    logic        b_isif [4];

    vecs[0] = mk("idle", 0, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0, 64'hFFFF,
                 0, 64'h0, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 0, 64'h0);
    vecs[1] = mk("if_fetch", 1, 64'h8000_0010, 0, 0, 64'h0, 64'h0, 64'h0, 64'hDEAD,
                 1, 64'h2, 0, 64'h0, 64'h0, 64'h0, 1, 64'hDEAD, 0, 64'h0);
    vecs[2] = mk("if_unaligned", 1, 64'h8000_0004, 0, 0, 64'h0, 64'h0, 64'h0, 64'h1234,
                 1, 64'h0, 0, 64'h0, 64'h0, 64'h0, 1, 64'h1234, 0, 64'h0);
    vecs[3] = mk("mem_store", 0, 64'h0, 1, 1, 64'h8000_0008, 64'h55, 64'hFF, 64'h9999,
                 0, 64'h0, 1, 64'h1, 64'h55, 64'hFF, 0, 64'h0, 1, 64'h0);
    vecs[4] = mk("mem_load", 0, 64'h0, 1, 0, 64'h8000_0100, 64'h0, 64'h0, 64'hCAFE,
                 1, 64'h20, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1, 64'hCAFE);
    vecs[5] = mk("load_below_base", 0, 64'h0, 1, 0, 64'h0, 64'h0, 64'h0, 64'hBEEF,
                 1, 64'h1FFF_FFFF_F000_0000, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1, 64'hBEEF);
    vecs[6] = mk("both_mem_wins", 1, 64'h8000_0800, 1, 0, 64'h8000_0018, 64'h0, 64'h0, 64'h4242,
                 1, 64'h3, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1, 64'h4242);
    vecs[7] = mk("store_unaligned", 0, 64'h0, 1, 1, 64'h8000_000F, 64'hA5A5_0000_1111_2222,
                 64'hFFFF_0000_FFFF_0000, 64'h7777,
                 0, 64'h0, 1, 64'h1, 64'hA5A5_0000_1111_2222, 64'hFFFF_0000_FFFF_0000,
                 0, 64'h0, 1, 64'h0);

    clear_a();
    bus_a.ram_rdata = 64'hFFFF;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.mem_req = 1'b0; bus_b.mem_we = 1'b0;
    bus_b.mem_addr = '0; bus_b.mem_wdata = '0; bus_b.mem_wmask = '0; bus_b.ram_rdata = '0;

    // Reset: outputs quiet even with a request present.
    bus_a.if_req = 1'b1; bus_a.if_addr = 64'h8000_0010;
    @(negedge clk); #1;
    check_grant_a("reset", 0, 64'h0, 0, 64'h0, 64'h0, 64'h0);
    check_resp_a("reset", 0, 64'h0, 0, 64'h0);
    clear_a();
    @(negedge clk); rst = 1'b1;

    // Table of single transactions, each starting from IDLE.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_a(vecs[i]);
      #1;
      check_grant_a({vecs[i].name, ".grant"}, vecs[i].g_en, vecs[i].g_ridx, vecs[i].g_wen,
                    vecs[i].g_widx, vecs[i].g_wdata, vecs[i].g_wmask);
      @(negedge clk); #1;
      check_resp_a({vecs[i].name, ".resp"}, vecs[i].r_if_ack, vecs[i].r_if_rdata,
                    vecs[i].r_mem_ack, vecs[i].r_mem_rdata);
      clear_a();
    end

    // Reset in RESP_MEM drops the ack; the still-held request is served after release.
    @(negedge clk);
    bus_a.mem_req = 1'b1; bus_a.mem_we = 1'b0; bus_a.mem_addr = 64'h8000_0028;
    bus_a.ram_rdata = 64'h77;
    #1;
    check_grant_a("rst_mid.grant", 1, 64'h5, 0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.mem_ack", 64'(bus_a.mem_ack), 64'd0);
    chk("rst_mid.mem_rdata", bus_a.mem_rdata, 64'h0);
    chk("rst_mid.ram_en", 64'(bus_a.ram_en), 64'd0);
    chk("rst_mid.ram_ridx", bus_a.ram_ridx, 64'h0);
    @(posedge clk); #1;
    chk("rst_hold.mem_ack", 64'(bus_a.mem_ack), 64'd0);
    chk("rst_hold.ram_en", 64'(bus_a.ram_en), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_grant_a("rst_reissue.grant", 1, 64'h5, 0, 64'h0, 64'h0, 64'h0);
    @(negedge clk); #1;
    check_resp_a("rst_reissue.resp", 0, 64'h0, 1, 64'h77);
    clear_a();

    // Simultaneous requests with a clear counter: MEM first, IF on the next IDLE.
    @(negedge clk);
    bus_a.if_req = 1'b1; bus_a.if_addr = 64'h8000_0030;
    bus_a.mem_req = 1'b1; bus_a.mem_we = 1'b0; bus_a.mem_addr = 64'h8000_0020;
    bus_a.ram_rdata = 64'h1111;
    #1;
    check_grant_a("tie.mem_grant", 1, 64'h4, 0, 64'h0, 64'h0, 64'h0);
    @(negedge clk); #1;
    check_resp_a("tie.mem_resp", 0, 64'h0, 1, 64'h1111);
    bus_a.mem_req = 1'b0; bus_a.ram_rdata = 64'h2222;
    @(negedge clk); #1;
    check_grant_a("tie.if_grant", 1, 64'h6, 0, 64'h0, 64'h0, 64'h0);
    @(negedge clk); #1;
    check_resp_a("tie.if_resp", 1, 64'h2222, 0, 64'h0);
    clear_a();

    // A request raised during RESP_IF waits for the next IDLE cycle.
    @(negedge clk);
    bus_a.if_req = 1'b1; bus_a.if_addr = 64'h8000_0008; bus_a.ram_rdata = 64'h3333;
    #1;
    check_grant_a("late.if_grant", 1, 64'h1, 0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    bus_a.mem_req = 1'b1; bus_a.mem_we = 1'b1; bus_a.mem_addr = 64'h8000_0010;
    bus_a.mem_wdata = 64'hAB; bus_a.mem_wmask = 64'hF0;
    #1;
    check_resp_a("late.if_resp", 1, 64'h3333, 0, 64'h0);
    chk("late.ram_widx_in_resp", bus_a.ram_widx, 64'h0);
    bus_a.if_req = 1'b0;
    @(negedge clk); #1;
    check_grant_a("late.mem_grant", 0, 64'h0, 1, 64'h2, 64'hAB, 64'hF0);
    @(negedge clk); #1;
    check_resp_a("late.mem_resp", 0, 64'h0, 1, 64'h0);
    clear_a();

    // Starvation with STARVE_MAX=2: MEM, MEM, forced IF, then MEM again (counter cleared).
    b_idx[0] = 64'h8; b_isif[0] = 1'b0;
    b_idx[1] = 64'h8; b_isif[1] = 1'b0;
    b_idx[2] = 64'h10; b_isif[2] = 1'b1;
    b_idx[3] = 64'h8; b_isif[3] = 1'b0;
    @(negedge clk);
    bus_b.if_req = 1'b1; bus_b.if_addr = 64'h8000_0080;
    bus_b.mem_req = 1'b1; bus_b.mem_we = 1'b0; bus_b.mem_addr = 64'h8000_0040;
    bus_b.ram_rdata = 64'h5;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("starve%0d.ram_en", k), 64'(bus_b.ram_en), 64'd1);
      chk($sformatf("starve%0d.ram_ridx", k), bus_b.ram_ridx, b_idx[k]);
      @(negedge clk); #1;
      chk($sformatf("starve%0d.if_ack", k), 64'(bus_b.if_ack), 64'(b_isif[k]));
      chk($sformatf("starve%0d.mem_ack", k), 64'(bus_b.mem_ack), 64'(!b_isif[k]));
      if (k == 3) begin
        bus_b.if_req = 1'b0; bus_b.mem_req = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    chk("starve.idle_ram_en", 64'(bus_b.ram_en), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BASE, 64'h8000_0000, byte address mapped to RAM word index 0.
REQ-002 Parameter: STARVE_MAX, 4, consecutive IF losses before IF is forced to win (range 1..15).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: if_req  in  1  instruction-fetch request; held with if_addr stable until if_ack.
REQ-006 Port: if_addr  in  64  fetch byte address.
REQ-007 Port: if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 Port: if_rdata  out  64  fetched 64-bit word.
REQ-009 Port: mem_req  in  1  load/store request; held with mem_* stable until mem_ack.
REQ-010 Port: mem_we  in  1  1 = store, 0 = load.
REQ-011 Port: mem_addr  in  64  load/store byte address.
REQ-012 Port: mem_wdata  in  64  store data.
REQ-013 Port: mem_wmask  in  64  store bit mask.
REQ-014 Port: mem_ack  out  1  one-cycle pulse: load/store complete.
REQ-015 Port: mem_rdata  out  64  load data, valid with mem_ack.
REQ-016 Port: ram_en  out  1  RAM read enable.
REQ-017 Port: ram_ridx  out  64  RAM read word index.
REQ-018 Port: ram_rdata  in  64  RAM read data, valid the cycle after ram_en.
REQ-019 Port: ram_wen  out  1  RAM write enable.
REQ-020 Port: ram_widx  out  64  RAM write word index.
REQ-021 Port: ram_wdata  out  64  RAM write data.
REQ-022 Port: ram_wmask  out  64  RAM write mask.

Function
REQ-023 FSM states IDLE, RESP_IF, RESP_MEM; only IDLE samples requests.
REQ-024 IDLE, no request: stay IDLE; all ram_* outputs 0.
REQ-025 IDLE, grant (grant cycle): ram_* driven combinationally from winner; next state RESP_IF or RESP_MEM.
REQ-026 Word index = (addr - BASE) >> 3, 64-bit modulo subtraction; addr[2:0] ignored.
REQ-027 IF grant: ram_en=1, ram_ridx=index(if_addr), ram_wen=0.
REQ-028 MEM load grant: ram_en=1, ram_ridx=index(mem_addr), ram_wen=0.
REQ-029 MEM store grant: ram_en=0, ram_wen=1, ram_widx=index(mem_addr), ram_wdata=mem_wdata, ram_wmask=mem_wmask.
REQ-030 RESP_IF: if_ack=1, if_rdata=ram_rdata; next IDLE.
REQ-031 RESP_MEM: mem_ack=1; mem_rdata=ram_rdata for load, 0 for store; next IDLE.
REQ-032 Latency: ack exactly 1 cycle after grant; max throughput one transaction per 2 cycles.
REQ-033 rdata outputs 0 whenever corresponding ack is 0; acks never both 1.
REQ-034 Priority: both requesting in IDLE -> MEM wins unless starve counter == STARVE_MAX, then IF wins.
REQ-035 Starve counter (4-bit): +1 when IF requests in IDLE and loses; cleared on IF grant; saturates at STARVE_MAX.
REQ-036 Requester must drop req the cycle after its ack; req still high in following IDLE = new request.
REQ-037 Request rising during RESP_* is not granted until next IDLE cycle.

Reset
REQ-038 rst low: state IDLE, starve counter 0, all outputs 0, immediately (asynchronous).
REQ-039 Reset during RESP_*: pending ack discarded; requester reissues after release.
REQ-040 First grant possible in first IDLE cycle after rst deasserts.

Verification
REQ-041 if_req, if_addr=0x8000_0010, ram_rdata=0xDEAD -> grant cycle ram_en=1, ram_ridx=2; next cycle if_ack=1, if_rdata=0xDEAD.
REQ-042 mem store addr=0x8000_0008, wdata=0x55, wmask=0xFF -> ram_wen=1, ram_widx=1, ram_en=0; next cycle mem_ack=1, mem_rdata=0.
REQ-043 if_req and mem_req simultaneous, STARVE_MAX=4 -> MEM granted first; IF granted next IDLE (counter 1, no force needed).
REQ-044 mem_req held continuously with IF pending, STARVE_MAX=2 -> MEM, MEM, then IF forced; counter 0 after IF grant.
REQ-045 rst low during RESP_MEM -> mem_ack stays 0, all ram_* 0; after release, reissued request acked 2 cycles later.
REQ-046 if_addr=0x8000_0004 -> ram_ridx=0 (addr[2:0] ignored).
